nvme_axil_responder: RTL
========================

NVME_AXIL_RESPONDER -- requirements
Module: nvme_axil_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32: AXI-Lite address width.
REQ-002 SHALL have parameter REG_SPACE_BYTES, default 4096: decoded register space size in bytes.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: local-ack timeout; 0 disables the timeout.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: axi_aclk, axi_aresetn.
REQ-005 axi_aclk  in  1  clock; all logic rising-edge.
REQ-006 axi_aresetn  in  1  asynchronous active-low reset.
REQ-007 s_axi_awaddr in ADDR_BITS; s_axi_awprot in 3 (ignored); s_axi_awvalid in 1; s_axi_awready out 1.
REQ-008 s_axi_wdata in 32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1.
REQ-009 s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
REQ-010 s_axi_araddr in ADDR_BITS; s_axi_arprot in 3 (ignored); s_axi_arvalid in 1; s_axi_arready out 1.
REQ-011 s_axi_rdata out 32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
REQ-012 reg_write out 1 (request level); reg_waddr out ADDR_BITS; reg_wdata out 32; reg_wstrb out 4; reg_wack in 1.
REQ-013 reg_read out 1 (request level); reg_raddr out ADDR_BITS; reg_rdata in 32; reg_rack in 1.

Function
REQ-014 Write FSM SHALL have states W_IDLE, W_REQ, W_RESP; read FSM SHALL have states R_IDLE, R_REQ, R_RESP; the two FSMs SHALL run independently and concurrently.
REQ-015 In W_IDLE, awready and wready SHALL each be 1 until their channel is captured, then 0; AW and W SHALL be accepted in either order or the same cycle.
REQ-016 W_IDLE SHALL go to W_REQ the cycle after both AW and W are captured; address is forwarded with bits [1:0] forced to 0.
REQ-017 If the captured address is >= REG_SPACE_BYTES, the FSM SHALL skip W_REQ, assert no reg_write, and go to W_RESP with bresp=2'b11 (DECERR).
REQ-018 In W_REQ, reg_write SHALL be held 1 with stable waddr/wdata/wstrb until reg_wack=1; then W_RESP with bresp=2'b00.
REQ-019 If TIMEOUT_CYCLES>0 and no reg_wack arrives within TIMEOUT_CYCLES cycles in W_REQ, SHALL drop reg_write and go to W_RESP with bresp=2'b10 (SLVERR).
REQ-020 Ack and timeout expiry in the same cycle SHALL resolve as ack (OKAY).
REQ-021 In W_RESP, bvalid SHALL be 1 with stable bresp until bready=1, then W_IDLE; minimum latency from last of AW/W handshake to bvalid is 2 cycles with a 0-cycle ack.
REQ-022 Read path SHALL mirror REQ-015..REQ-021: arready=1 in R_IDLE; DECERR returns rdata=32'h0; timeout returns rresp=2'b10 and rdata=32'hDEADBEEF; on reg_rack, rdata SHALL be captured from reg_rdata that cycle.
REQ-023 rvalid SHALL hold with stable rdata/rresp until rready=1.
REQ-024 reg_wack/reg_rack asserted outside W_REQ/R_REQ SHALL be ignored.
REQ-025 Timeout counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits, cleared on REQ entry, saturating, never wrapping.
REQ-026 At most one outstanding write and one outstanding read SHALL exist.

Reset
REQ-027 On axi_aresetn=0, all outputs SHALL be 0 asynchronously and both FSMs SHALL enter IDLE; awready/wready/arready SHALL rise the first clock after reset release.
REQ-028 Reset mid-transaction SHALL abandon it with no B/R response and drop reg_write/reg_read immediately.

Structure
REQ-029 Response codes (OKAY, SLVERR, DECERR), the timeout-rdata constant, and FSM state enums SHALL live in shared package nvme_axil_pkg.
REQ-030 The timeout counter SHALL be sub-module nvme_axil_timeout, instantiated once per FSM.

Verification
REQ-031 AW then W 3 cycles later, addr=0x10, data=0xA5A5A5A5, ack after 2 cycles -> one reg_write with waddr=0x10, bresp=00, single bvalid.
REQ-032 araddr=0x2000 with REG_SPACE_BYTES=4096 -> no reg_read, rresp=11, rdata=0.
REQ-033 TIMEOUT_CYCLES=8, read never acked -> reg_read drops after 8 cycles, rresp=10, rdata=0xDEADBEEF.
REQ-034 Simultaneous write and read, both acked same cycle -> both complete OKAY; bready/rready held 0 for 5 cycles keeps bvalid/rvalid and payload stable.
REQ-035 Reset asserted during W_REQ -> reg_write falls without a clock, no bvalid after release, next write completes normally.
REQ-036 Ack in the exact timeout cycle -> OKAY; unsolicited reg_wack in W_IDLE -> no bvalid.

Source files
------------

// File: rtl/nvme_axil_pkg.sv
// Shared response codes, timeout read data and FSM state types for the
// NVMe AXI-Lite register responder.
package nvme_axil_pkg;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [1:0]  RESP_DECERR   = 2'b11;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

endpackage

// File: rtl/nvme_axil_responder_if.sv
// AXI4-Lite channel bundle; slave modport faces the responder.
interface nvme_axil_responder_if #(
    parameter int ADDR_BITS = 32
) ();

    logic [ADDR_BITS-1:0] awaddr;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [ADDR_BITS-1:0] araddr;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );

endinterface

// File: rtl/nvme_axil_timeout.sv
// Saturating cycle counter for a pending local request. expired is high in
// the TIMEOUT_CYCLES-th consecutive cycle of run; TIMEOUT_CYCLES=0 disables it.
module nvme_axil_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] SAT   = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // Count cycles spent running; idle cycles clear it so each request starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (count != SAT) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES > 0) && run && (count >= LIMIT);

endmodule

// File: rtl/nvme_axil_responder.sv
// AXI4-Lite slave that forwards single register reads/writes to a local
// request/ack port, with address decode and ack timeout. Write and read
// paths are independent FSMs.
module nvme_axil_responder
    import nvme_axil_pkg::*;
#(
    parameter int ADDR_BITS       = 32,
    parameter int REG_SPACE_BYTES = 4096,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    nvme_axil_responder_if.slave s_axi,
    output logic                 reg_write,
    output logic [ADDR_BITS-1:0] reg_waddr,
    output logic [31:0]          reg_wdata,
    output logic [3:0]           reg_wstrb,
    input  logic                 reg_wack,
    output logic                 reg_read,
    output logic [ADDR_BITS-1:0] reg_raddr,
    input  logic [31:0]          reg_rdata,
    input  logic                 reg_rack
);

    localparam logic [ADDR_BITS-1:0] SPACE_LIMIT = ADDR_BITS'(REG_SPACE_BYTES);

    w_state_e             w_state;
    r_state_e             r_state;
    logic                 aw_done, w_done, ar_done;
    logic                 aw_cap, w_cap, ar_cap;
    logic                 w_run, r_run, w_expired, r_expired;
    logic [ADDR_BITS-1:0] w_addr, r_addr;
    logic [31:0]          w_data;
    logic [3:0]           w_strb;

    assign aw_cap = s_axi.awvalid && s_axi.awready;
    assign w_cap  = s_axi.wvalid  && s_axi.wready;
    assign ar_cap = s_axi.arvalid && s_axi.arready;
    assign w_run  = (w_state == W_REQ);
    assign r_run  = (r_state == R_REQ);

    nvme_axil_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_w_timeout (
        .clk(axi_aclk), .rst_n(axi_aresetn), .run(w_run), .expired(w_expired)
    );

    nvme_axil_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_r_timeout (
        .clk(axi_aclk), .rst_n(axi_aresetn), .run(r_run), .expired(r_expired)
    );

    // State-derived outputs so reset clears them without waiting for a clock.
    assign reg_write    = w_run;
    assign reg_read     = r_run;
    assign s_axi.bvalid = (w_state == W_RESP);
    assign s_axi.rvalid = (r_state == R_RESP);
    assign reg_waddr    = w_addr;
    assign reg_wdata    = w_data;
    assign reg_wstrb    = w_strb;
    assign reg_raddr    = r_addr;

    // Write path: collect AW and W in any order, issue local write, return B.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state       <= W_IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            w_addr        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_axi.awready <= !(aw_done || aw_cap);
                    s_axi.wready  <= !(w_done || w_cap);
                    if (aw_cap) begin
                        aw_done <= 1'b1;
                        w_addr  <= {s_axi.awaddr[ADDR_BITS-1:2], 2'b00};
                    end
                    if (w_cap) begin
                        w_done <= 1'b1;
                        w_data <= s_axi.wdata;
                        w_strb <= s_axi.wstrb;
                    end
                    if (aw_done && w_done) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (w_addr >= SPACE_LIMIT) begin
                            s_axi.bresp <= RESP_DECERR;
                            w_state     <= W_RESP;
                        end else begin
                            w_state <= W_REQ;
                        end
                    end
                end
                W_REQ: begin
                    if (reg_wack) begin
                        s_axi.bresp <= RESP_OKAY;
                        w_state     <= W_RESP;
                    end else if (w_expired) begin
                        s_axi.bresp <= RESP_SLVERR;
                        w_state     <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        s_axi.awready <= 1'b1;
                        s_axi.wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path: capture AR, issue local read, return R with captured data.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state       <= R_IDLE;
            ar_done       <= 1'b0;
            r_addr        <= '0;
            s_axi.arready <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi.arready <= !(ar_done || ar_cap);
                    if (ar_cap) begin
                        ar_done <= 1'b1;
                        r_addr  <= {s_axi.araddr[ADDR_BITS-1:2], 2'b00};
                    end
                    if (ar_done) begin
                        ar_done <= 1'b0;
                        if (r_addr >= SPACE_LIMIT) begin
                            s_axi.rdata <= '0;
                            s_axi.rresp <= RESP_DECERR;
                            r_state     <= R_RESP;
                        end else begin
                            r_state <= R_REQ;
                        end
                    end
                end
                R_REQ: begin
                    if (reg_rack) begin
                        s_axi.rdata <= reg_rdata;
                        s_axi.rresp <= RESP_OKAY;
                        r_state     <= R_RESP;
                    end else if (r_expired) begin
                        s_axi.rdata <= TIMEOUT_RDATA;
                        s_axi.rresp <= RESP_SLVERR;
                        r_state     <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi.rready) begin
                        s_axi.arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule
